aes_inv_seq: RTL and testbench

Parametrised iterative AES inverse-cipher sequencer. It accepts one ciphertext block over a valid/ready handshake and runs the initial AddRoundKey. It then drives an external single-cycle inverse-round datapath through Nr rounds selected by key length, and presents the plaintext on a held valid/ready output. It sits between the key-expansion unit, which supplies a pre-reversed round-key schedule, and downstream consumers such as the display and UART.

---
 rtl/aes_inv_seq.sv | 119 +++++++++++
 tb/tb_aes_inv_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_seq.sv
// Iterative AES inverse-cipher sequencer: initial AddRoundKey, then Nr passes
// through an external combinational inverse-round datapath, result held on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a ciphertext block, in_ready high
// ROUND | one inverse round per cycle through round_out, busy high
// DONE  | plaintext held on out_data until out_ready; may accept the next block on the same edge
module aes_inv_seq #(
  parameter int BLOCK_W = 128,
  parameter int MAX_NR  = 14,
  parameter int RND_W   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      key_len,
  input  logic [BLOCK_W*(MAX_NR+1)-1:0]   key_sched,
  input  logic [BLOCK_W-1:0]              in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BLOCK_W-1:0]              round_in,
  output logic [BLOCK_W-1:0]              round_key,
  output logic                            round_last,
  input  logic [BLOCK_W-1:0]              round_out,
  output logic [BLOCK_W-1:0]              out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic [RND_W-1:0]                dbg_round
);

  localparam int NSLOT = 2 ** RND_W;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [RND_W-1:0]   rnd, rnd_d;
  logic [RND_W-1:0]   nr, nr_d;
  logic               accept;

  // Slot table padded to the full counter range so every rnd value indexes a defined entry.
  logic [BLOCK_W-1:0] slot [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i <= MAX_NR) begin : g_used
      assign slot[i] = key_sched[i*BLOCK_W +: BLOCK_W];
    end else begin : g_unused
      assign slot[i] = '0;
    end
  end

  function automatic logic [RND_W-1:0] nr_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return RND_W'(10);
      2'b01:   return RND_W'(12);
      default: return RND_W'(14);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      rnd     <= '0;
      nr      <= RND_W'(10);
    end else begin
      fsm     <= fsm_nxt;
      state_q <= state_d;
      rnd     <= rnd_d;
      nr      <= nr_d;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_d   = state_q;
    rnd_d     = rnd;
    nr_d      = nr;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ROUND: begin
        busy    = 1'b1;
        state_d = round_out;
        if (rnd == nr) fsm_nxt = DONE;
        else           rnd_d   = rnd + RND_W'(1);
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) accept  = 1'b1;
          else          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
    // Acceptance from DONE overrides the return to IDLE, removing the bubble.
    if (accept) begin
      state_d = in_data ^ slot[0];
      rnd_d   = RND_W'(1);
      nr_d    = nr_of(key_len);
      fsm_nxt = ROUND;
    end
  end

  assign round_in   = state_q;
  assign round_key  = slot[rnd];
  assign round_last = (fsm == ROUND) && (rnd == nr);
  assign out_data   = state_q;
  assign dbg_round  = (fsm == IDLE) ? '0 : rnd;

endmodule

// File: tb/tb_aes_inv_seq.sv
// Self-checking bench for aes_inv_seq: software AES key expansion and inverse cipher
// supply both the external round datapath and the expected plaintext.
module tb_aes_inv_seq;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    key_len;
  logic [1919:0] key_sched;
  logic [127:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  round_in, round_key, round_out, out_data;
  logic          round_last, out_valid, out_ready, busy;
  logic [3:0]    dbg_round;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk [15];
  int           nr_m;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_inv_seq dut (
    .clk(clk), .rst_n(rst_n), .key_len(key_len), .key_sched(key_sched),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .round_in(round_in), .round_key(round_key), .round_last(round_last),
    .round_out(round_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .dbg_round(dbg_round)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  // One standard inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] u;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*((c + r) % 4)] = isbox[b[r + 4*c]];
    for (int i = 0; i < 16; i++) u[127-8*i -: 8] = t[i];
    u = u ^ k;
    if (!last) begin
      for (int i = 0; i < 16; i++) b[i] = u[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        t[4*c]   = gmul(b[4*c],8'h0e)^gmul(b[4*c+1],8'h0b)^gmul(b[4*c+2],8'h0d)^gmul(b[4*c+3],8'h09);
        t[4*c+1] = gmul(b[4*c],8'h09)^gmul(b[4*c+1],8'h0e)^gmul(b[4*c+2],8'h0b)^gmul(b[4*c+3],8'h0d);
        t[4*c+2] = gmul(b[4*c],8'h0d)^gmul(b[4*c+1],8'h09)^gmul(b[4*c+2],8'h0e)^gmul(b[4*c+3],8'h0b);
        t[4*c+3] = gmul(b[4*c],8'h0b)^gmul(b[4*c+1],8'h0d)^gmul(b[4*c+2],8'h09)^gmul(b[4*c+3],8'h0e);
      end
      for (int i = 0; i < 16; i++) u[127-8*i -: 8] = t[i];
    end
    return u;
  endfunction

  assign round_out = inv_round(round_in, round_key, round_last);

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Expands a left-justified key of nk words; schedule slot i holds round key nr-i.
  task automatic make_sched(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    nr_m = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr_m+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr_m; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int s = 0; s < 15; s++)
      key_sched[s*128 +: 128] = (s <= nr_m) ? rk[nr_m-s] : {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s = ct ^ rk[nr_m];
    for (int r = nr_m - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic [1:0] kl, input string name);
    int n = 0;
    key_len  = kl;
    in_data  = ct;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin step(); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept timeout: in_ready=%b required 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Follows a block from the sample point just after its acceptance edge to DONE.
  task automatic track(input logic [127:0] pt, input int nr_exp, input bit scramble,
                       input string name);
    int cnt = 0;
    int rl  = 0;
    while (!out_valid && cnt < 40) begin
      total++;
      if (dbg_round !== 4'(cnt + 1) || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s round step %0d: dbg_round=%0d busy=%b required %0d/1",
                 name, cnt, dbg_round, busy, cnt + 1);
      end
      if (round_last === 1'b1) begin
        rl++;
        total++;
        if (cnt + 1 != nr_exp) begin
          bad++;
          $display("FAIL %s round_last position: round %0d required %0d", name, cnt + 1, nr_exp);
        end
      end
      if (scramble) key_len = 2'($urandom);
      step();
      cnt++;
    end
    total++;
    if (cnt != nr_exp) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, nr_exp);
    end
    total++;
    if (out_data !== pt) begin
      bad++;
      $display("FAIL %s out_data: got %h required %h", name, out_data, pt);
    end
    total++;
    if (rl != 1) begin
      bad++;
      $display("FAIL %s round_last pulses: got %0d required 1", name, rl);
    end
    total++;
    if (in_ready !== out_ready || busy !== 1'b0 || dbg_round !== 4'(nr_exp)) begin
      bad++;
      $display("FAIL %s done flags: in_ready=%b busy=%b dbg_round=%0d required %b/0/%0d",
               name, in_ready, busy, dbg_round, out_ready, nr_exp);
    end
  endtask

  task automatic go_idle(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_round !== 4'd0) begin
      bad++;
      $display("FAIL %s return to idle: in_ready=%b out_valid=%b dbg_round=%0d required 1/0/0",
               name, in_ready, out_valid, dbg_round);
    end
  endtask

  task automatic test_reset();
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0 ||
          dbg_round !== 4'd0 || round_last !== 1'b0) begin
        bad++;
        $display("FAIL reset values (phase %0d): in_ready=%b out_valid=%b busy=%b out_data=%h dbg=%0d last=%b required 1/0/0/0/0/0",
                 k, in_ready, out_valid, busy, out_data, dbg_round, round_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
    end
  endtask

  task automatic test_fips();
    make_sched(K128, 4);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, "aes128");
    track(PT_FIPS, 10, 1'b0, "aes128");
    go_idle("aes128");
    make_sched(K192, 6);
    send(128'hdda97ca4864cdfe06eaf70a0ec0d7191, 2'b01, "aes192");
    track(PT_FIPS, 12, 1'b0, "aes192");
    go_idle("aes192");
    make_sched(K256, 8);
    send(128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, "aes256_kl10");
    track(PT_FIPS, 14, 1'b0, "aes256_kl10");
    go_idle("aes256_kl10");
    send(128'h8ea2b7ca516745bfeafc49904b496089, 2'b11, "aes256_kl11");
    track(PT_FIPS, 14, 1'b0, "aes256_kl11");
    go_idle("aes256_kl11");
  endtask

  task automatic test_backpressure();
    make_sched(K128, 4);
    out_ready = 1'b0;
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, "backpressure");
    track(PT_FIPS, 10, 1'b0, "backpressure");
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== PT_FIPS || in_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL backpressure hold %0d: out_valid=%b out_data=%h in_ready=%b busy=%b required 1/%h/0/0",
                 c, out_valid, out_data, in_ready, busy, PT_FIPS);
      end
    end
    go_idle("backpressure");
  endtask

  task automatic test_back_to_back();
    logic [127:0] ca, cb, pa, pb;
    make_sched(K128, 4);
    ca = {$urandom, $urandom, $urandom, $urandom};
    cb = {$urandom, $urandom, $urandom, $urandom};
    pa = ref_decrypt(ca);
    pb = ref_decrypt(cb);
    out_ready = 1'b1;
    send(ca, 2'b00, "b2b_first");
    in_data  = cb;
    in_valid = 1'b1;
    track(pa, 10, 1'b0, "b2b_first");
    step();
    in_valid = 1'b0;
    track(pb, 10, 1'b0, "b2b_second");
    go_idle("b2b_second");
  endtask

  task automatic test_abort();
    int n = 0;
    make_sched(K256, 8);
    send(128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, "abort");
    while (dbg_round !== 4'd5 && n < 20) begin step(); n++; end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0 ||
        dbg_round !== 4'd0 || round_last !== 1'b0) begin
      bad++;
      $display("FAIL abort reset values: in_ready=%b out_valid=%b busy=%b out_data=%h dbg=%0d last=%b required 1/0/0/0/0/0",
               in_ready, out_valid, busy, out_data, dbg_round, round_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, "abort_next");
    track(PT_FIPS, 14, 1'b0, "abort_next");
    go_idle("abort_next");
  endtask

  task automatic test_keylen_change();
    make_sched(K128, 4);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, "keylen_change");
    track(PT_FIPS, 10, 1'b1, "keylen_change");
    go_idle("keylen_change");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int           nk = 4 + 2 * (it % 3);
      logic [1:0]   kl;
      logic [127:0] ct, pt;
      logic [255:0] key = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
      kl = (nk == 4) ? 2'b00 : (nk == 6) ? 2'b01 : 2'(2 + $urandom_range(0, 1));
      make_sched(key, nk);
      ct = {$urandom, $urandom, $urandom, $urandom};
      pt = ref_decrypt(ct);
      send(ct, kl, $sformatf("random%0d", it));
      track(pt, nk + 6, 1'b0, $sformatf("random%0d", it));
      go_idle($sformatf("random%0d", it));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_len   = 2'b00;
    key_sched = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    build_tables();
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_keylen_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
